// File: rtl/divisor_secuencial.sv
// ============================================================================
// Module   : divisor_secuencial (with helper restador)
// Brief    : Multi-cycle unsigned restoring divider. A single shared N+1-bit
//            subtractor performs one trial subtraction per cycle over N
//            iterations. start/busy/done handshake; results held until the
//            next accepted start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Trial subtractor: Result = num1 - num2 (mod 2^W), Carryout = no borrow.
module restador #(
  parameter int W = 5
) (
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  output logic [W-1:0] Result,
  output logic         Carryout
);

  logic [W:0] diff;

  // One extra bit captures the borrow of the unsigned subtraction.
  assign diff     = {1'b0, num1} - {1'b0, num2};
  assign Result   = diff[W-1:0];
  assign Carryout = ~diff[W];

endmodule

module divisor_secuencial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  // Trial subtraction operands: shifted partial remainder against divisor.
  logic [N:0]   trial;
  logic [N:0]   divisor_ext;
  logic [N:0]   sub_res;
  logic         sub_carry;
  logic [N-1:0] iter_r_next;
  logic [N-1:0] iter_q_next;

  assign trial       = {r_q, q_q[N-1]};
  assign divisor_ext = {1'b0, d_q};

  restador #(.W(N + 1)) u_restador (
    .num1     (trial),
    .num2     (divisor_ext),
    .Result   (sub_res),
    .Carryout (sub_carry)
  );

  // Restore step: keep the difference only when the divisor fit.
  assign iter_r_next = sub_carry ? sub_res[N-1:0] : trial[N-1:0];
  assign iter_q_next = {q_q[N-2:0], sub_carry};

  // Next-state and datapath update for the IDLE/ITER/DONE sequence.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor == '0) begin
            // Divide-by-zero short-circuits straight to DONE.
            state_d     = S_DONE;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_ITER;
            q_d     = dividend;
            r_d     = '0;
            d_d     = divisor;
            cnt_d   = CW'(N);
            dbz_d   = 1'b0;
          end
        end
      end
      S_ITER: begin
        r_d   = iter_r_next;
        q_d   = iter_q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          quotient_d  = iter_q_next;
          remainder_d = iter_r_next;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_divisor_secuencial.sv
// ============================================================================
// Module   : tb_divisor_secuencial
// Brief    : Self-checking bench for divisor_secuencial at N=4 and N=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divisor_secuencial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start4 = 1'b0;
  logic [3:0] dvd4 = '0, dvs4 = '0;
  logic       busy4, done4, dz4;
  logic [3:0] q4, r4;

  logic       start8 = 1'b0;
  logic [7:0] dvd8 = '0, dvs8 = '0;
  logic       busy8, done8, dz8;
  logic [7:0] q8, r8;

  int total = 0;
  int bad   = 0;

  divisor_secuencial #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dz4)
  );

  divisor_secuencial #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  // Issue one N=4 request and wait (bounded) for done; lat counts the start
  // edge as cycle 1, so a normal op reports N+1 and divide-by-zero reports 1.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat, output int busy_cnt);
    dvd4 = a; dvs4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; dvd4 = 4'($urandom); dvs4 = 4'($urandom);
    lat = 1; busy_cnt = 0;
    while (!done4 && lat < 20) begin
      if (busy4) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy4) busy_cnt++;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
    dvd8 = a; dvs8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
    lat = 1;
    while (!done8 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy4); end
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done4); end
    total++; if (q4 !== 4'd0) begin bad++; $display("FAIL reset_quot: got %0d want 0", q4); end
    total++; if (r4 !== 4'd0) begin bad++; $display("FAIL reset_rem: got %0d want 0", r4); end
    total++; if (dz4 !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", dz4); end
    total++; if (q8 !== 8'd0 || busy8 !== 1'b0) begin bad++; $display("FAIL reset_n8: got q=%0d busy=%b want 0/0", q8, busy8); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc;
    run4(4'd10, 4'd3, lat, bc);
    total++; if (q4 !== 4'd3) begin bad++; $display("FAIL basic_quot: got %0d want 3", q4); end
    total++; if (r4 !== 4'd1) begin bad++; $display("FAIL basic_rem: got %0d want 1", r4); end
    total++; if (dz4 !== 1'b0) begin bad++; $display("FAIL basic_dbz: got %b want 0", dz4); end
    total++; if (lat != 5) begin bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
    total++; if (bc != 5) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 5", bc); end
    @(posedge clk); #1;
    total++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin bad++; $display("FAIL basic_pulse_end: got done=%b busy=%b want 0/0", done4, busy4); end
    repeat (3) begin
      dvd4 = 4'($urandom); dvs4 = 4'($urandom);
      @(posedge clk); #1;
    end
    total++; if (q4 !== 4'd3 || r4 !== 4'd1) begin bad++; $display("FAIL basic_hold: got q=%0d r=%0d want 3/1", q4, r4); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run4(4'd15, 4'd1, lat, bc);
    total++; if (q4 !== 4'd15 || r4 !== 4'd0) begin bad++; $display("FAIL b2b_first: got q=%0d r=%0d want 15/0", q4, r4); end
    @(posedge clk); #1;
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL b2b_pulse: got done=%b want 0", done4); end
    run4(4'd5, 4'd7, lat, bc);
    total++; if (q4 !== 4'd0 || r4 !== 4'd5) begin bad++; $display("FAIL b2b_second: got q=%0d r=%0d want 0/5", q4, r4); end
    total++; if (lat != 5) begin bad++; $display("FAIL b2b_latency: got %0d want 5", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run4(4'd9, 4'd0, lat, bc);
    total++; if (lat != 1) begin bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
    total++; if (q4 !== 4'b1111 || r4 !== 4'd9) begin bad++; $display("FAIL dz_result: got q=%0d r=%0d want 15/9", q4, r4); end
    total++; if (dz4 !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", dz4); end
    total++; if (bc != 1) begin bad++; $display("FAIL dz_busy_cycles: got %0d want 1", bc); end
    @(posedge clk); #1;
    total++; if (done4 !== 1'b0 || busy4 !== 1'b0 || dz4 !== 1'b1) begin bad++; $display("FAIL dz_after: got done=%b busy=%b dbz=%b want 0/0/1", done4, busy4, dz4); end
    run4(4'd8, 4'd2, lat, bc);
    total++; if (q4 !== 4'd4 || r4 !== 4'd0 || dz4 !== 1'b0) begin bad++; $display("FAIL dz_next: got q=%0d r=%0d dbz=%b want 4/0/0", q4, r4, dz4); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int pulses, dk;
    logic [3:0] gq, gr;
    pulses = 0; dk = -1; gq = '0; gr = '0;
    dvd4 = 4'd12; dvs4 = 4'd5; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    total++; if (q4 !== 4'd4 || busy4 !== 1'b1) begin bad++; $display("FAIL ign_hold_old: got q=%0d busy=%b want 4/1", q4, busy4); end
    @(posedge clk); #1;
    dvd4 = 4'd15; dvs4 = 4'd1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 2; k < 14; k++) begin
      if (done4) begin pulses++; dk = k; gq = q4; gr = r4; end
      @(posedge clk); #1;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
    total++; if (dk != 4) begin bad++; $display("FAIL ign_timing: got edge %0d want 4", dk); end
    total++; if (gq !== 4'd2 || gr !== 4'd2) begin bad++; $display("FAIL ign_result: got q=%0d r=%0d want 2/2", gq, gr); end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    logic seen;
    seen = 1'b0;
    dvd4 = 4'd14; dvs4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (busy4 !== 1'b0 || done4 !== 1'b0 || q4 !== 4'd0 || r4 !== 4'd0 || dz4 !== 1'b0) begin
      bad++; $display("FAIL abort_clear: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0", busy4, done4, q4, r4, dz4);
    end
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | done4;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %b want 0", seen); end
    rst = 1'b0;
    run4(4'd14, 4'd3, lat, bc);
    total++; if (q4 !== 4'd4 || r4 !== 4'd2) begin bad++; $display("FAIL abort_rerun: got q=%0d r=%0d want 4/2", q4, r4); end
    total++; if (lat != 5) begin bad++; $display("FAIL abort_latency: got %0d want 5", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_random4();
    int lat, bc, a, b, eq, er, el;
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      if (b == 0) begin eq = 15; er = a; el = 1; end
      else begin eq = a / b; er = a % b; el = 5; end
      run4(4'(a), 4'(b), lat, bc);
      total++; if (int'(q4) != eq || int'(r4) != er || dz4 !== (b == 0)) begin
        bad++; $display("FAIL rnd4 %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d", a, b, q4, r4, dz4, eq, er);
      end
      total++; if (lat != el) begin bad++; $display("FAIL rnd4_latency %0d/%0d: got %0d want %0d", a, b, lat, el); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random8();
    int lat, a, b;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      run8(8'(a), 8'(b), lat);
      total++; if (int'(q8) * b + int'(r8) != a || int'(r8) >= b || int'(q8) != a / b) begin
        bad++; $display("FAIL rnd8 %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d", a, b, q8, r8, a / b, a % b);
      end
      total++; if (lat != 9 || dz8 !== 1'b0) begin bad++; $display("FAIL rnd8_latency %0d/%0d: got lat=%0d dbz=%b want 9/0", a, b, lat, dz8); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_random4();
    test_random8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
